sqrt: RTL and testbench
=======================

// Module: sqrt
//
// PURPOSE
//   Gradient-magnitude unit for the image filter datapath.
//   Takes two unsigned components (e.g. horizontal/vertical gradients) and
//   produces out = min(2^WIDTH-1, floor(sqrt(in1^2 + in2^2))).
//   Fully pipelined: accepts a new operand pair every clock, fixed latency.
//   No handshake; the downstream consumer samples out on a fixed cycle offset.
//
// PARAMETERS
//   WIDTH  8  bit width of in1, in2 and out
//     - Sum width is 2*WIDTH+1.
//     - Root width is WIDTH+1.
//
// PORTS
//   clk  in   1      single clock, all logic on rising edge
//   rst  in   1      synchronous, active-low reset (0 = reset)
//   in1  in   WIDTH  unsigned component A, sampled every clk edge
//   in2  in   WIDTH  unsigned component B, sampled every clk edge
//   out  out  WIDTH  registered saturated magnitude
//
// BEHAVIOUR
//   - Reset: while rst==0 at a clk edge, every pipeline register and out are
//     cleared to 0. Reset mid-stream flushes all in-flight results.
//     After rst rises, out stays 0 until the first sampled pair emerges.
//   - Stage S0 (edge 1): register sum = in1*in1 + in2*in2 (2*WIDTH+1 bits, no
//     overflow; max 130050 for WIDTH=8).
//   - Stages R1..R(WIDTH+1) (edges 2..WIDTH+2): restoring digit-by-digit sqrt.
//     - Each stage resolves one root bit, MSB first.
//     - Per stage: trial = (rem<<2 | next 2 radicand bits) - (root<<2 | 1).
//     - If trial >= 0: rem = trial, root bit = 1.
//     - Otherwise: rem keeps the shifted value, root bit = 0.
//     - Each stage carries radicand, partial root and remainder forward.
//   - Output stage (edge WIDTH+3): out = (root > 2^WIDTH-1) ? 2^WIDTH-1 : root.
//   - Latency: a pair present before edge k appears on out after edge k+WIDTH+2.
//     For WIDTH=8 that is 11 edges, i.e. out is valid 11 cycles after sampling.
//   - Throughput: 1 result per clock; consecutive pairs emerge in order.
//   - in1/in2 may change every cycle; each pair is processed independently.
//   - Boundaries (WIDTH=8):
//     - 0,0 -> 0.
//     - Exact squares are exact: 3,4 -> 5.
//     - Roots above 255 saturate: 255,255 -> sqrt 360 -> 255.
//     - Pure axis is identity: x,0 -> x.
//   - All arithmetic is unsigned; no X propagation once reset has been applied.
//
// CONFIGURATION
//   SQRT_ROUND_EN
//     - Undefined: out = floor(sqrt(sum)), as above.
//     - Defined: round to nearest.
//       - After the final root stage, if remainder > root, then root = root + 1.
//         Since sum >= r^2 + r + 1, sqrt exceeds r + 0.5.
//       - Rounding happens in the output stage, before saturation.
//       - Latency and reset behaviour are unchanged.
//
// TESTING
//   1. rst=0 held, in1=in2=100, clocks running -> out==0 on every edge.
//   2. rst 0->1, in1=in2=100 held -> out==141 from the 11th edge after release.
//   3. Single pairs, each held 11+ cycles:
//      - 0,0 -> 0.
//      - 3,4 -> 5.
//      - 180,0 -> 180.
//      - 2,3 -> 3 (4 with SQRT_ROUND_EN).
//      - 200,100 -> 223 (224 with SQRT_ROUND_EN).
//   4. Saturation: 255,255 -> 255; 200,200 (root 282) -> 255.
//   5. Streaming: new pair each cycle (3,4),(100,100),(255,255),(0,0) ->
//      5,141,255,0 on 4 consecutive edges starting 11 edges after the first.
//   6. Mid-stream reset: rst=0 for 1 edge while pipeline is full ->
//      - out==0 on the following edge.
//      - No pre-reset results ever appear.
//      - Post-reset pairs emerge after 11 edges.

Source files
------------

// File: rtl/sqrt.sv
// Pipelined gradient magnitude: out = min(2^WIDTH-1, floor(sqrt(in1^2 + in2^2))).
// Define SQRT_ROUND_EN to round the root to nearest instead of truncating.
module sqrt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned RW   = WIDTH + 1;
  localparam int unsigned RADW = 2 * RW;
  localparam int unsigned REMW = WIDTH + 4;
  localparam int unsigned TW   = REMW + 1;
  localparam int unsigned NST  = RW;

  // rad_q[0] is the squared sum; rad_q[s] feeds root stage s with its top two bits
  logic [RADW-1:0]  rad_q  [0:NST-1];
  logic [RADW-1:0]  rad_d  [0:NST-1];
  logic [RW-1:0]    root_q [0:NST-1];
  logic [RW-1:0]    root_d [0:NST-1];
  logic [REMW-1:0]  rem_q  [0:NST-1];
  logic [REMW-1:0]  rem_d  [0:NST-1];
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [RW:0]      root_r;

  function automatic logic [REMW+RW-1:0] sqrt_step(
    input logic [REMW-1:0] rem,
    input logic [RW-1:0]   root,
    input logic [1:0]      bits
  );
    logic [REMW-1:0] sh;
    logic [TW-1:0]   trial;
    sh    = {rem[REMW-3:0], bits};
    trial = {1'b0, sh} - TW'({root, 2'b01});
    if (!trial[TW-1]) return {trial[REMW-1:0], root[RW-2:0], 1'b1};
    else              return {sh, root[RW-2:0], 1'b0};
  endfunction

  always_comb begin
    rad_d[0] = RADW'(in1) * RADW'(in1) + RADW'(in2) * RADW'(in2);
    {rem_d[0], root_d[0]} = sqrt_step('0, '0, rad_q[0][RADW-1 -: 2]);
    for (int unsigned s = 1; s < NST; s++) begin
      rad_d[s] = rad_q[s-1] << 2;
      {rem_d[s], root_d[s]} = sqrt_step(rem_q[s-1], root_q[s-1], rad_q[s][RADW-1 -: 2]);
    end

    root_r = {1'b0, root_q[NST-1]};
`ifdef SQRT_ROUND_EN
    // remainder > root means sum >= r^2 + r + 1, so sqrt lies above r + 0.5
    if (rem_q[NST-1] > REMW'(root_q[NST-1])) root_r = root_r + 1'b1;
`endif
    out_d = (root_r[RW:WIDTH] != '0) ? '1 : root_r[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned s = 0; s < NST; s++) begin
        rad_q[s]  <= '0;
        root_q[s] <= '0;
        rem_q[s]  <= '0;
      end
      out_q <= '0;
    end else begin
      for (int unsigned s = 0; s < NST; s++) begin
        rad_q[s]  <= rad_d[s];
        root_q[s] <= root_d[s];
        rem_q[s]  <= rem_d[s];
      end
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_sqrt.sv
// Directed bench for sqrt (WIDTH=8): reset, latency, exact/saturating values,
// streaming order and mid-stream flush.
module tb_sqrt;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [7:0] out;

  int vectors    = 0;
  int miscompares = 0;

  sqrt #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .in1 (in1),
    .in2 (in2),
    .out (out)
  );

  always #5 clk = ~clk;

  // advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    vectors++;
    assert (out === exp)
    else begin
      miscompares++;
      $error("FAIL %s: out=%0d expected=%0d", tag, out, exp);
    end
  endtask

  // hold a pair, take 11 edges, check the result only at the 11th
  task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp);
    in1 = a;
    in2 = b;
    for (int i = 0; i < 11; i++) tick();
    check(tag, exp);
  endtask

  initial begin
    rst = 1'b0;
    in1 = 8'd100;
    in2 = 8'd100;

    // held in reset
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_hold", 8'd0);
    end

    // release: zero through edge 10, 141 from edge 11
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("post_release_zero", 8'd0);
    end
    tick();
    check("first_result_141", 8'd141);
    tick();
    check("held_141", 8'd141);

    single("zero_zero", 8'd0,   8'd0,   8'd0);
    single("three_four", 8'd3,  8'd4,   8'd5);
    single("axis_180",   8'd180, 8'd0,  8'd180);
`ifdef SQRT_ROUND_EN
    single("two_three",  8'd2,   8'd3,   8'd4);
    single("200_100",    8'd200, 8'd100, 8'd224);
`else
    single("two_three",  8'd2,   8'd3,   8'd3);
    single("200_100",    8'd200, 8'd100, 8'd223);
`endif
    single("axis_y_77",  8'd0,   8'd77,  8'd77);
    single("sat_255",    8'd255, 8'd255, 8'd255);
    single("sat_200",    8'd200, 8'd200, 8'd255);

    // streaming: pipeline full of (200,200) -> 255, then four new pairs
    in1 = 8'd3;   in2 = 8'd4;   tick();
    in1 = 8'd100; in2 = 8'd100; tick();
    in1 = 8'd255; in2 = 8'd255; tick();
    in1 = 8'd0;   in2 = 8'd0;   tick();
    for (int i = 5; i <= 10; i++) tick();
    check("stream_not_early", 8'd255);
    tick(); check("stream_0", 8'd5);
    tick(); check("stream_1", 8'd141);
    tick(); check("stream_2", 8'd255);
    tick(); check("stream_3", 8'd0);

    // fill with (255,255), flush with a one-edge reset, then feed (3,4)
    in1 = 8'd255; in2 = 8'd255;
    for (int i = 0; i < 12; i++) tick();
    check("prefill_255", 8'd255);
    in1 = 8'd3; in2 = 8'd4;
    rst = 1'b0;
    tick();
    check("midreset_clear", 8'd0);
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("flush_no_stale", 8'd0);
    end
    tick();
    check("post_flush_5", 8'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
